dm_scan_driver: RTL

- Downstream stage of the bomb-game top level. It takes an 8x8 bitmap frame from game logic and time-multiplexes it onto the dot-matrix column and row pins.
- Uses a double buffer: a new frame is latched as pending and swapped into the displayed buffer only at a frame boundary, so tearing cannot occur.
- Inserts a blanking interval before each row to suppress ghosting.

---
 rtl/dm_pkg.sv | 17 +
 rtl/dm_scan_timer.sv | 49 ++++
 rtl/dm_scan_driver.sv | 80 ++++++++
 3 files changed

// File: rtl/dm_pkg.sv
// Shared constants and helpers for the dot-matrix scan driver.
package dm_pkg;

  localparam int DM_ROWS = 8;
  localparam int DM_COLS = 8;
  localparam int FRAME_W = 64;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  // Row r of a frame lives in bits [8r+7:8r].
  function automatic logic [DM_COLS-1:0] row_byte(input logic [FRAME_W-1:0] frame,
                                                  input logic [2:0]         row);
    return frame[{row, 3'b000} +: DM_COLS];
  endfunction

endpackage

// File: rtl/dm_scan_timer.sv
// Row-slot timing: cycle counter, row index and blank/drive state.
module dm_scan_timer
  import dm_pkg::*;
#(
  parameter int ROW_DIV   = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [2:0] row_idx_o,
  output logic       in_drive_o,
  output logic       row_end_o,
  output logic       frame_end_o,
  output logic       state_o
);

  localparam int            CW        = (ROW_DIV > 1) ? $clog2(ROW_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(ROW_DIV - 1);
  localparam logic [CW-1:0] CNT_DRIVE = CW'(BLANK_CYC);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    row_q, row_d;
  logic          row_end;

  assign row_end = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = row_end ? '0 : cnt_q + 1'b1;
    row_d = row_end ? row_q + 3'd1 : row_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      row_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      row_q <= row_d;
    end
  end

  // The state is a pure function of the counter, so it can never drift from it.
  assign state_o     = (cnt_q < CNT_DRIVE) ? ST_BLANK : ST_DRIVE;
  assign in_drive_o  = (state_o == ST_DRIVE);
  assign row_idx_o   = row_q;
  assign row_end_o   = row_end;
  assign frame_end_o = row_end && (row_q == 3'd7);

endmodule

// File: rtl/dm_scan_driver.sv
// Double-buffered 8x8 dot-matrix scanner with per-row blanking.
// Handshake: i_fLoad is a one-cycle strobe with no back-pressure; o_Pending is high while a frame waits for the swap.
module dm_scan_driver
  import dm_pkg::*;
#(
  parameter int ROW_DIV   = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_fLoad,
  input  logic [FRAME_W-1:0] i_Frame,
  input  logic               i_Blank,
  output logic [DM_COLS-1:0] o_DM_Col,
  output logic [DM_ROWS-1:0] o_DM_Row,
  output logic               o_Pending,
  output logic               o_fFrameDone,
  output logic [4:0]         o_Dbg
);

  logic [2:0] row_idx;
  logic       in_drive, row_end, frame_end, state;

  dm_scan_timer #(
    .ROW_DIV   (ROW_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk_i       (i_Clk),
    .rst_i       (i_Rst),
    .row_idx_o   (row_idx),
    .in_drive_o  (in_drive),
    .row_end_o   (row_end),
    .frame_end_o (frame_end),
    .state_o     (state)
  );

  logic [FRAME_W-1:0] pend_q, pend_d;
  logic [FRAME_W-1:0] disp_q, disp_d;
  logic               pending_q, pending_d;
  logic [DM_COLS-1:0] col_q, col_d;
  logic [DM_ROWS-1:0] dm_row_q, dm_row_d;
  logic               done_q, done_d;
  logic               drive;

  always_comb begin
    drive     = in_drive && !i_Blank;
    // A load coinciding with the swap lands in pending after the old contents move out.
    pend_d    = i_fLoad ? i_Frame : pend_q;
    disp_d    = (frame_end && pending_q) ? pend_q : disp_q;
    pending_d = i_fLoad || (pending_q && !frame_end);
    dm_row_d  = drive ? (8'd1 << row_idx) : 8'd0;
    col_d     = drive ? row_byte(disp_q, row_idx) : 8'd0;
    done_d    = frame_end;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      pend_q    <= '0;
      disp_q    <= '0;
      pending_q <= 1'b0;
      col_q     <= '0;
      dm_row_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      col_q     <= col_d;
      dm_row_q  <= dm_row_d;
      done_q    <= done_d;
    end
  end

  assign o_DM_Col     = col_q;
  assign o_DM_Row     = dm_row_q;
  assign o_Pending    = pending_q;
  assign o_fFrameDone = done_q;
  assign o_Dbg        = {row_idx, state, row_end};

endmodule
